// File: rtl/pulse_meter.sv
// Measures the spacing in clk cycles between successive events on sig and reports it
// with a one-cycle strobe; tracks consecutive matches against an expected spacing to assert lock.
module pulse_meter #(
  parameter int count_reg_size = 16,
  parameter int pulsemode      = 1,
  parameter int expected       = 2,
  parameter int lock_count     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      sig,
  output logic [count_reg_size-1:0] period,
  output logic                      valid,
  output logic                      overflow,
  output logic                      match,
  output logic                      locked,
  output logic                      busy
);

  localparam int W  = count_reg_size;
  localparam int MW = $clog2(lock_count + 1);
  localparam logic [W-1:0]  CMAX = '1;
  localparam logic [W-1:0]  EXP  = W'(expected);
  localparam logic [MW-1:0] LOCK = MW'(lock_count);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

  state_t         state, state_nxt;
  logic           sig_q, evt;
  logic [W-1:0]   cnt, cnt_inc;
  logic           sat, hit;
  logic           start, strobe;
  logic [MW-1:0]  mcnt;

  assign evt     = (pulsemode != 0) ? (sig & ~sig_q) : (sig ^ sig_q);
  assign cnt_inc = (cnt == CMAX) ? CMAX : cnt + 1'b1;
  assign hit     = (cnt == EXP) && !sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // enable=0 wins over everything, including an event in the same cycle
  always_comb begin
    state_nxt = state;
    if (!enable) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    state_nxt = ARM;
        ARM:     if (evt) state_nxt = MEASURE;
        MEASURE: state_nxt = MEASURE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy   = (state != IDLE);
    start  = enable && (state == ARM) && evt;
    strobe = enable && (state == MEASURE) && evt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q    <= 1'b0;
      cnt      <= '0;
      sat      <= 1'b0;
      period   <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
      match    <= 1'b0;
    end else begin
      sig_q    <= sig;
      valid    <= strobe;
      overflow <= strobe & sat;
      match    <= strobe & hit;
      if (strobe) period <= sat ? CMAX : cnt;
      // the opening event and every measured event both restart the count at 1
      if (start || strobe) begin
        cnt <= {{(W-1){1'b0}}, 1'b1};
        sat <= 1'b0;
      end else if (enable && state == MEASURE) begin
        cnt <= cnt_inc;
        sat <= sat | (cnt_inc == CMAX);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      mcnt <= '0;
    else if (!enable) mcnt <= '0;
    else if (strobe) begin
      if (!hit)              mcnt <= '0;
      else if (mcnt != LOCK) mcnt <= mcnt + 1'b1;
    end
  end

  assign locked = (mcnt == LOCK);

endmodule

// File: tb/tb_pulse_meter.sv
// Two pulse_meter instances (16-bit rising-edge, 4-bit toggle) share stimulus; an event-time
// reference model feeds per-instance scoreboards that negedge monitors drain on each strobe.
module tb_pulse_meter;

  logic clk = 1'b0;
  logic rst_n, enable, sig;
  logic [15:0] period_a;
  logic [3:0]  period_b;
  logic valid_a, overflow_a, match_a, locked_a, busy_a;
  logic valid_b, overflow_b, match_b, locked_b, busy_b;

  always #5 clk = ~clk;

  pulse_meter #(.count_reg_size(16), .pulsemode(1), .expected(2), .lock_count(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sig(sig), .period(period_a), .valid(valid_a),
    .overflow(overflow_a), .match(match_a), .locked(locked_a), .busy(busy_a));

  pulse_meter #(.count_reg_size(4), .pulsemode(0), .expected(2), .lock_count(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sig(sig), .period(period_b), .valid(valid_b),
    .overflow(overflow_b), .match(match_b), .locked(locked_b), .busy(busy_b));

  typedef struct {int period; bit ovf; bit match; bit locked;} exp_t;

  exp_t q[2][$];
  int   ph[2];     // 0 idle, 1 armed, 2 measuring
  int   mc[2];
  int   last[2];
  int   lastp[2];
  bit   prev[2];
  int   now = 0;
  int   nchk = 0, nerr = 0;

  task automatic chk(int i, string nm, int act, int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL dut%0d %s: got %0d want %0d (t=%0t)", i, nm, act, exp, $time);
    end
  endtask

  // Spacing rule: N = cycles between events; the count tops out at 2^W-1, which flags overflow.
  task automatic model_step(int i, bit en, bit s);
    int   maxv, n;
    bit   ev;
    exp_t e;
    maxv = (i == 0) ? 65535 : 15;
    ev   = (i == 0) ? (s & ~prev[i]) : (s ^ prev[i]);
    prev[i] = s;
    if (!en) begin
      ph[i] = 0;
      mc[i] = 0;
    end else if (ph[i] == 0) ph[i] = 1;
    else if (ph[i] == 1) begin
      if (ev) begin ph[i] = 2; last[i] = now; end
    end else if (ev) begin
      n        = now - last[i];
      last[i]  = now;
      e.ovf    = (n >= maxv);
      e.period = e.ovf ? maxv : n;
      e.match  = (n == 2) && !e.ovf;
      mc[i]    = e.match ? ((mc[i] < 4) ? mc[i] + 1 : 4) : 0;
      e.locked = (mc[i] == 4);
      lastp[i] = e.period;
      q[i].push_back(e);
    end
  endtask

  task automatic mon(int i, bit v, int p, bit o, bit m, bit l);
    exp_t e;
    if (v) begin
      if (q[i].size() == 0) chk(i, "unexpected_valid", 1, 0);
      else begin
        e = q[i].pop_front();
        chk(i, "period", p, e.period);
        chk(i, "overflow", o, e.ovf);
        chk(i, "match", m, e.match);
        chk(i, "locked", l, e.locked);
      end
    end else begin
      chk(i, "overflow_idle", o, 0);
      chk(i, "match_idle", m, 0);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, valid_a, int'(period_a), overflow_a, match_a, locked_a);
      mon(1, valid_b, int'(period_b), overflow_b, match_b, locked_b);
    end
  end

  task automatic tick(bit en, bit s);
    @(posedge clk); #1;
    chk(0, "busy", busy_a, int'(ph[0] != 0));
    chk(1, "busy", busy_b, int'(ph[1] != 0));
    enable = en; sig = s; now++;
    model_step(0, en, s);
    model_step(1, en, s);
  endtask

  task automatic pulse(int g);
    tick(1, 1);
    repeat (g - 1) tick(1, 0);
  endtask

  task automatic chk_zero(string nm);
    chk(0, {nm, "_outs"}, int'({period_a, valid_a, overflow_a, match_a, locked_a, busy_a}), 0);
    chk(1, {nm, "_outs"}, int'({period_b, valid_b, overflow_b, match_b, locked_b, busy_b}), 0);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 2; i++) begin
      q[i].delete();
      ph[i] = 0; mc[i] = 0; last[i] = 0; lastp[i] = 0; prev[i] = 0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; enable = 1'b0; sig = 1'b0;
    #1 chk_zero("async_reset");
    clear_model();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    bit lvl;
    rst_n = 1'b1; enable = 1'b0; sig = 1'b0;
    clear_model();
    #2 rst_n = 1'b0;
    #2 chk_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // steady 2-cycle pulses: lock on dut_a
    tick(1, 0); tick(1, 0);
    repeat (12) pulse(2);
    // one pulse delayed, then the 2-cycle pattern resumes
    pulse(3);
    repeat (7) pulse(2);
    // toggle every 3 cycles
    lvl = 1'b1;
    repeat (8) begin repeat (3) tick(1, lvl); lvl = ~lvl; end
    tick(1, 0); tick(1, 0);
    // long gaps saturate the 4-bit counter, then short spacing recovers
    pulse(20); pulse(20); pulse(2); pulse(2); pulse(2);
    // stuck-high sig
    repeat (40) tick(1, 1);
    tick(1, 0);
    repeat (3) pulse(2);
    // enable dropped in the same cycle as an event
    repeat (4) pulse(2);
    tick(0, 1);
    tick(0, 0);
    chk(0, "locked_after_disable", locked_a, 0);
    chk(0, "period_hold", int'(period_a), lastp[0]);
    chk(1, "period_hold", int'(period_b), lastp[1]);
    repeat (3) tick(0, 0);
    tick(1, 0);
    repeat (6) pulse(2);
    // reset in the middle of a measurement
    tick(1, 1); tick(1, 0); tick(1, 0);
    do_reset();
    tick(1, 1);
    repeat (6) pulse(2);
    // random traffic
    repeat (400) tick($urandom_range(0, 19) != 0, 1'($urandom_range(0, 1)));
    repeat (3) tick(1, 0);
    @(negedge clk); #1;
    chk(0, "pending_strobes", q[0].size(), 0);
    chk(1, "pending_strobes", q[1].size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
